// File: rtl/lsu_pkg.sv
// Purpose : shared types, opcodes and decode helpers for the byte-serial load/store unit.
// Latency : n/a (types, constants and pure functions only).
// Backpres: n/a.
// Contents: AluSelBus/AluOpBus/RegAddrBus, load/store opcodes, FSM state enum, byte helpers.
package lsu_pkg;

   typedef logic [2:0] AluSelBus;
   typedef logic [7:0] AluOpBus;
   typedef logic [4:0] RegAddrBus;

   localparam AluSelBus EXE_RES_LOAD_STORE = 3'b111;

   localparam AluOpBus EXE_LB_OP  = 8'b1110_0000;
   localparam AluOpBus EXE_LH_OP  = 8'b1110_0001;
   localparam AluOpBus EXE_LW_OP  = 8'b1110_0011;
   localparam AluOpBus EXE_LBU_OP = 8'b1110_0100;
   localparam AluOpBus EXE_LHU_OP = 8'b1110_0101;
   localparam AluOpBus EXE_SB_OP  = 8'b1110_1000;
   localparam AluOpBus EXE_SH_OP  = 8'b1110_1001;
   localparam AluOpBus EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [2:0] {IDLE, LOAD, STORE, WAIT, DONE} lsu_state_t;

   function automatic logic is_load_op(AluOpBus op);
      case (op)
         EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_store_op(AluOpBus op);
      case (op)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // An unrecognised aluop under the load/store class is not a memory op.
   function automatic logic is_mem_op(AluSelBus sel, AluOpBus op);
      return (sel == EXE_RES_LOAD_STORE) && (is_load_op(op) || is_store_op(op));
   endfunction

   // Index of the last byte transferred (byte count minus one).
   function automatic logic [1:0] last_byte(AluOpBus op);
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
         EXE_LW_OP, EXE_SW_OP:             return 2'd3;
         default:                          return 2'd0;
      endcase
   endfunction

   function automatic logic [7:0] get_byte(logic [31:0] w, logic [1:0] idx);
      case (idx)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] put_byte(logic [31:0] w, logic [1:0] idx, logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (idx)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Purpose : bundles the EX request, writeback and byte-wide RAM signals of the LSU.
// Latency : n/a (wires only).
// Backpres: stall_req from the LSU holds the pipeline; no other flow control.
// Modports: master = pipeline/RAM side driving requests and ram_din; slave = LSU.
interface lsu_if;
   import lsu_pkg::*;

   AluSelBus    alusel;
   AluOpBus     aluop;
   logic [31:0] mem_addr;
   logic [31:0] st_data;
   logic        we;
   RegAddrBus   waddr;
   logic [31:0] alu_wdata;

   logic        wb_we;
   RegAddrBus   wb_waddr;
   logic [31:0] wb_wdata;
   logic        stall_req;

   logic [31:0] ram_a;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        ram_wr;

   modport master (
      output alusel, aluop, mem_addr, st_data, we, waddr, alu_wdata, ram_din,
      input  wb_we, wb_waddr, wb_wdata, stall_req, ram_a, ram_dout, ram_wr
   );

   modport slave (
      input  alusel, aluop, mem_addr, st_data, we, waddr, alu_wdata, ram_din,
      output wb_we, wb_waddr, wb_wdata, stall_req, ram_a, ram_dout, ram_wr
   );

endinterface

// File: rtl/lsu_extend.sv
// Purpose : sign/zero extends the assembled little-endian load word by access size.
// Latency : combinational.
// Backpres: none.
// Ports   : i_aluop (load opcode), i_raw (assembled bytes), o_data (writeback value).
module lsu_extend
   import lsu_pkg::*;
(
   input  AluOpBus     i_aluop,
   input  logic [31:0] i_raw,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_raw;
      case (i_aluop)
         EXE_LB_OP:  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
         EXE_LBU_OP: o_data = {24'd0, i_raw[7:0]};
         EXE_LH_OP:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
         EXE_LHU_OP: o_data = {16'd0, i_raw[15:0]};
         default:    o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Purpose : byte-serial load/store unit; non-memory ops pass straight through to writeback.
// Latency : pass-through 0 cycles; store n+1 cycles to DONE; load n+2 cycles to DONE (n = 1/2/4 bytes).
// Backpres: stall_req holds EX from the request cycle until the cycle before DONE; no RAM backpressure.
// Ports   : clk, rst (async, active-high); bus (lsu_if.slave) carries EX request, writeback and RAM port.
module lsu
   import lsu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);

   lsu_state_t  r_state;
   logic [1:0]  r_k;
   AluOpBus     r_aluop;
   logic [31:0] r_addr;
   logic [31:0] r_st_data;
   RegAddrBus   r_waddr;
   logic [31:0] r_raw;
   logic [31:0] r_ram_a;
   logic [7:0]  r_ram_dout;
   logic        r_ram_wr;

   logic        w_is_mem;
   logic [1:0]  w_last;
   logic [31:0] w_next_a;
   logic [31:0] w_ext;

   assign w_is_mem = is_mem_op(bus.alusel, bus.aluop);
   assign w_last   = last_byte(r_aluop);
   // 32-bit add wraps naturally, so misaligned accesses may cross 0xFFFFFFFF.
   assign w_next_a = r_addr + {30'd0, r_k} + 32'd1;

   lsu_extend u_extend (
      .i_aluop (r_aluop),
      .i_raw   (r_raw),
      .o_data  (w_ext)
   );

   // RAM outputs are registered: each transition loads the address/data for the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_k        <= 2'd0;
         r_aluop    <= '0;
         r_addr     <= '0;
         r_st_data  <= '0;
         r_waddr    <= '0;
         r_raw      <= '0;
         r_ram_a    <= '0;
         r_ram_dout <= '0;
         r_ram_wr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_is_mem) begin
                  r_aluop   <= bus.aluop;
                  r_addr    <= bus.mem_addr;
                  r_st_data <= bus.st_data;
                  r_waddr   <= bus.waddr;
                  r_k       <= 2'd0;
                  r_raw     <= '0;
                  r_ram_a   <= bus.mem_addr;
                  if (is_load_op(bus.aluop)) begin
                     r_state <= LOAD;
                  end else begin
                     r_state    <= STORE;
                     r_ram_wr   <= 1'b1;
                     r_ram_dout <= bus.st_data[7:0];
                  end
               end
            end
            LOAD: begin
               // ram_din now holds the byte addressed in the previous cycle.
               if (r_k != 2'd0) begin
                  r_raw <= put_byte(r_raw, r_k - 2'd1, bus.ram_din);
               end
               if (r_k == w_last) begin
                  r_state <= WAIT;
                  r_ram_a <= '0;
               end else begin
                  r_k     <= r_k + 2'd1;
                  r_ram_a <= w_next_a;
               end
            end
            WAIT: begin
               r_raw   <= put_byte(r_raw, w_last, bus.ram_din);
               r_state <= DONE;
            end
            STORE: begin
               if (r_k == w_last) begin
                  r_state    <= DONE;
                  r_ram_wr   <= 1'b0;
                  r_ram_a    <= '0;
                  r_ram_dout <= '0;
               end else begin
                  r_k        <= r_k + 2'd1;
                  r_ram_a    <= w_next_a;
                  r_ram_dout <= get_byte(r_st_data, r_k + 2'd1);
               end
            end
            // The request is still on the bus here; it is deliberately not re-accepted.
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.wb_we     = 1'b0;
      bus.wb_waddr  = '0;
      bus.wb_wdata  = '0;
      bus.stall_req = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (w_is_mem) begin
                  bus.stall_req = 1'b1;
               end else begin
                  bus.wb_we    = bus.we;
                  bus.wb_waddr = bus.waddr;
                  bus.wb_wdata = bus.alu_wdata;
               end
            end
            LOAD, STORE, WAIT: bus.stall_req = 1'b1;
            DONE: begin
               if (is_load_op(r_aluop)) begin
                  bus.wb_we    = 1'b1;
                  bus.wb_waddr = r_waddr;
                  bus.wb_wdata = w_ext;
               end
            end
            default: bus.stall_req = 1'b0;
         endcase
      end
   end

   assign bus.ram_a    = r_ram_a;
   assign bus.ram_dout = r_ram_dout;
   assign bus.ram_wr   = r_ram_wr;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   lsu_if bus_if();

   lsu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // kind 0 = RAM write (a=addr, d=byte), 1 = writeback (a=waddr, d=wdata), 2 = stall run (cyc=start, d=length)
   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   logic [7:0] mem [logic [31:0]];

   function automatic logic [7:0] rd(logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   function automatic ev_t mk(int kind, int c, logic [31:0] a, logic [31:0] d);
      ev_t e;
      e.kind = kind; e.cyc = c; e.a = a; e.d = d;
      return e;
   endfunction

   function automatic string kname(int kind);
      case (kind)
         0:       return "ram_write";
         1:       return "writeback";
         default: return "stall_run";
      endcase
   endfunction

   // Byte-wide RAM: write on the edge, read data for ram_a appears the following cycle.
   always @(posedge clk) begin
      if (bus_if.ram_wr) mem[bus_if.ram_a] = bus_if.ram_dout;
      bus_if.ram_din <= rd(bus_if.ram_a);
   end

   always @(posedge clk) cyc++;

   task automatic check_ev(ev_t got);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_%s: got cyc=%0d a=%h d=%h, required no event",
                  kname(got.kind), got.cyc, got.a, got.d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind == got.kind && e.cyc == got.cyc && e.a == got.a && e.d == got.d) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got %s cyc=%0d a=%h d=%h, required %s cyc=%0d a=%h d=%h",
                     kname(e.kind), kname(got.kind), got.cyc, got.a, got.d,
                     kname(e.kind), e.cyc, e.a, e.d);
         end
      end
   endtask

   // Monitor: observes DUT outputs mid-cycle and checks them against the expected-event queue.
   logic in_stall = 1'b0;
   int   st_start = 0;
   always @(negedge clk) begin
      if (bus_if.stall_req && !in_stall) begin
         in_stall = 1'b1;
         st_start = cyc;
      end else if (!bus_if.stall_req && in_stall) begin
         in_stall = 1'b0;
         check_ev(mk(2, st_start, 32'd0, cyc - st_start));
      end
      if (!rst && bus_if.ram_wr)
         check_ev(mk(0, cyc, bus_if.ram_a, {24'd0, bus_if.ram_dout}));
      if (!rst && bus_if.wb_we)
         check_ev(mk(1, cyc, {27'd0, bus_if.wb_waddr}, bus_if.wb_wdata));
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, got, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      bus_if.alusel    = 3'b000;
      bus_if.aluop     = 8'h00;
      bus_if.mem_addr  = 32'd0;
      bus_if.st_data   = 32'd0;
      bus_if.we        = 1'b0;
      bus_if.waddr     = 5'd0;
      bus_if.alu_wdata = 32'd0;
   endtask

   task automatic idle();
      next_cycle();
      nop();
      next_cycle();
   endtask

   task automatic wait_done(string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!bus_if.stall_req) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s_timeout: stall_req still 1 after 20 cycles, required release", name);
      end
   endtask

   // Memory op issued at cycle T and held through DONE; expected events pushed at issue time.
   task automatic mem_op(string name, AluOpBus op, logic [31:0] addr, logic [31:0] data,
                         RegAddrBus wa, int n, bit ld, logic [31:0] exp_wb);
      int t;
      next_cycle();
      t = cyc;
      bus_if.alusel    = EXE_RES_LOAD_STORE;
      bus_if.aluop     = op;
      bus_if.mem_addr  = addr;
      bus_if.st_data   = data;
      bus_if.waddr     = wa;
      bus_if.we        = ld;
      bus_if.alu_wdata = 32'h0BAD0BAD;
      if (ld) begin
         exp_q.push_back(mk(2, t, 32'd0, n + 2));
         exp_q.push_back(mk(1, t + n + 2, {27'd0, wa}, exp_wb));
      end else begin
         for (int k = 0; k < n; k++)
            exp_q.push_back(mk(0, t + 1 + k, addr + k, {24'd0, data[8*k +: 8]}));
         exp_q.push_back(mk(2, t, 32'd0, n + 1));
      end
      wait_done(name);
   endtask

   task automatic passthru(string name, AluSelBus sel, AluOpBus op, RegAddrBus wa, logic [31:0] wd);
      int t;
      next_cycle();
      t = cyc;
      bus_if.alusel    = sel;
      bus_if.aluop     = op;
      bus_if.mem_addr  = 32'h0000_0500;
      bus_if.we        = 1'b1;
      bus_if.waddr     = wa;
      bus_if.alu_wdata = wd;
      exp_q.push_back(mk(1, t, {27'd0, wa}, wd));
      @(negedge clk);
      chk({name, "_stall"}, {31'd0, bus_if.stall_req}, 32'd0);
      chk({name, "_ram_wr"}, {31'd0, bus_if.ram_wr}, 32'd0);
      next_cycle();
      nop();
   endtask

   initial begin
      int t;
      mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
      mem[32'h200] = 8'h80; mem[32'h201] = 8'h7F;
      mem[32'h300] = 8'h99; mem[32'h301] = 8'h34; mem[32'h302] = 8'hF2; mem[32'h303] = 8'h55;
      mem[32'h000] = 8'h11;

      // Reset with a pass-through request present: outputs must still be forced to zero.
      nop();
      bus_if.alusel    = 3'b001;
      bus_if.we        = 1'b1;
      bus_if.waddr     = 5'd9;
      bus_if.alu_wdata = 32'h0000CAFE;
      repeat (2) next_cycle();
      chk("rst_stall_req", {31'd0, bus_if.stall_req}, 32'd0);
      chk("rst_wb_we",     {31'd0, bus_if.wb_we},     32'd0);
      chk("rst_wb_waddr",  {27'd0, bus_if.wb_waddr},  32'd0);
      chk("rst_wb_wdata",  bus_if.wb_wdata,           32'd0);
      chk("rst_ram_wr",    {31'd0, bus_if.ram_wr},    32'd0);
      chk("rst_ram_a",     bus_if.ram_a,              32'd0);
      chk("rst_ram_dout",  {24'd0, bus_if.ram_dout},  32'd0);
      rst = 1'b0;
      nop();
      next_cycle();

      passthru("add", 3'b001, 8'h20, 5'd5, 32'd7);
      mem_op("lw",  EXE_LW_OP,  32'h100, 32'd0, 5'd2, 4, 1'b1, 32'h12345678); idle();
      mem_op("lb",  EXE_LB_OP,  32'h200, 32'd0, 5'd3, 1, 1'b1, 32'hFFFFFF80); idle();
      mem_op("lbu", EXE_LBU_OP, 32'h200, 32'd0, 5'd4, 1, 1'b1, 32'h00000080); idle();
      mem_op("lh_r0_misaligned", EXE_LH_OP, 32'h301, 32'd0, 5'd0, 2, 1'b1, 32'hFFFFF234); idle();
      mem_op("sh_wrap", EXE_SH_OP, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd7, 2, 1'b0, 32'd0); idle();
      chk("sh_mem_ffffffff", {24'd0, rd(32'hFFFFFFFF)}, 32'h000000DD);
      chk("sh_mem_00000000", {24'd0, rd(32'h00000000)}, 32'h000000CC);
      passthru("ls_bad_op", EXE_RES_LOAD_STORE, 8'h21, 5'd6, 32'd9);

      // Back-to-back store then load of the same word.
      mem_op("sw_40", EXE_SW_OP, 32'h40, 32'hDEADBEEF, 5'd1, 4, 1'b0, 32'd0);
      mem_op("lw_40", EXE_LW_OP, 32'h40, 32'd0, 5'd8, 4, 1'b1, 32'hDEADBEEF); idle();

      // Reset in the second write cycle of a SW.
      next_cycle();
      t = cyc;
      bus_if.alusel   = EXE_RES_LOAD_STORE;
      bus_if.aluop    = EXE_SW_OP;
      bus_if.mem_addr = 32'h80;
      bus_if.st_data  = 32'h11223344;
      exp_q.push_back(mk(0, t + 1, 32'h80, 32'h44));
      exp_q.push_back(mk(2, t, 32'd0, 2));
      next_cycle();
      next_cycle();
      rst = 1'b1;
      nop();
      #1;
      chk("midrst_ram_wr", {31'd0, bus_if.ram_wr}, 32'd0);
      chk("midrst_stall",  {31'd0, bus_if.stall_req}, 32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      repeat (5) next_cycle();
      chk("midrst_mem_80", {24'd0, rd(32'h80)}, 32'h00000044);
      chk("midrst_mem_81", {24'd0, rd(32'h81)}, 32'h00000000);
      passthru("add_after_rst", 3'b001, 8'h20, 5'd3, 32'h55);

      repeat (10) next_cycle();
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_checks++;
         $display("FAIL missing_%s: got no event, required cyc=%0d a=%h d=%h",
                  kname(e.kind), e.cyc, e.a, e.d);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port alusel, input, AluSelBus: result class from EX; EXE_RES_LOAD_STORE selects a memory operation.
REQ-004 SHALL have port aluop, input, AluOpBus: one of EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP for memory operations.
REQ-005 SHALL have port mem_addr, input, 32 bits: effective address (base + mem_offset, computed in EX).
REQ-006 SHALL have port st_data, input, 32 bits: store data (rs2 value).
REQ-007 SHALL have ports we (1), waddr (RegAddrBus), alu_wdata (32), input: writeback request from EX.
REQ-008 SHALL have ports wb_we (1), wb_waddr (RegAddrBus), wb_wdata (32), output: writeback to MEM/WB and to ID forwarding.
REQ-009 SHALL have port stall_req, output, 1 bit: pipeline hold request.
REQ-010 SHALL have ports ram_a (32, out), ram_dout (8, out), ram_din (8, in) and ram_wr (1, out): byte-wide RAM port; read data for ram_a in cycle t appears on ram_din in cycle t+1.

Function
REQ-011 SHALL provide states IDLE, LOAD, STORE, WAIT and DONE, plus a 2-bit byte counter k.
REQ-012 Non-memory op in IDLE: outputs SHALL be combinational pass-through (wb_we=we, wb_waddr=waddr, wb_wdata=alu_wdata, stall_req=0, ram_wr=0).
REQ-013 Memory op in IDLE (cycle T): SHALL latch aluop, address, store data and waddr, set k=0, assert stall_req combinationally, and go to LOAD or STORE.
REQ-014 Byte count n SHALL be 1 for LB/LBU/SB, 2 for LH/LHU/SH and 4 for LW/SW; data is little-endian, byte k at address+k with 32-bit wrap-around; misaligned addresses are legal.
REQ-015 STORE cycles T+1..T+n SHALL drive ram_a=addr+k, ram_dout=st_data[8k+7:8k] and ram_wr=1, then go to DONE at T+n+1.
REQ-016 LOAD cycles T+1..T+n SHALL drive ram_a=addr+k with ram_wr=0; ram_din SHALL be captured into assembly byte k-1 in cycles T+2..T+n+1, using WAIT for the final capture; DONE follows at T+n+2.
REQ-017 In DONE, stall_req SHALL be 0. For loads: wb_we=1, wb_waddr=latched waddr, wb_wdata = assembled data, sign-extended for LB/LH and zero-extended for LBU/LHU/LW. For stores: wb_we=0.
REQ-018 DONE SHALL return to IDLE unconditionally, ignoring the still-present same request, so each instruction is executed exactly once.
REQ-019 stall_req SHALL be 1 from cycle T through the cycle before DONE; ram_wr SHALL be 0 in every state except STORE.
REQ-020 A load with waddr=0 SHALL still perform RAM reads and SHALL drive wb_we=1 with waddr 0; the register file ignores it.
REQ-021 A memory alusel with an unrecognised aluop SHALL be treated as a non-memory op (pass-through).

Reset
REQ-022 While rst=1, the block SHALL set state=IDLE, k=0, all latched registers to 0, and drive stall_req=0, wb_we=0, wb_waddr=0, wb_wdata=0, ram_wr=0, ram_a=0 and ram_dout=0 immediately.
REQ-023 Reset asserted mid-store SHALL drop ram_wr in the same cycle; after release, the block SHALL start in IDLE with no partial writeback.

Structure
REQ-024 AluSelBus, AluOpBus, RegAddrBus, EXE_RES_LOAD_STORE and the load/store aluop codes SHALL come from the shared defines file; no local redefinition.
REQ-025 Load byte assembly and sign/zero extension SHALL be a combinational sub-module lsu_extend (inputs: aluop and 32-bit raw data; output: 32-bit result).

Verification
REQ-026 LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12 -> ram_a 0x100..0x103 in T+1..T+4; wb_we=1 with wb_wdata=0x12345678 at T+6; stall_req=1 for T..T+5.
REQ-027 LB and LBU at 0x200, byte 0x80 -> wb_wdata 0xFFFFFF80 and 0x00000080 respectively, both at T+3.
REQ-028 SH at 0xFFFFFFFF, st_data 0xAABBCCDD -> writes 0xDD@0xFFFFFFFF and 0xCC@0x00000000 with ram_wr=1; DONE at T+3 with wb_we=0.
REQ-029 ADD passthrough (we=1, waddr=5, alu_wdata=7) in IDLE -> same-cycle wb_* = 1/5/7, stall_req=0, ram_wr=0.
REQ-030 Back-to-back SW then LW at the same address 0x40, data 0xDEADBEEF -> LW returns 0xDEADBEEF; each op is executed exactly once.
REQ-031 rst pulse at T+2 of SW -> ram_wr=0 immediately; after release, no further writes and wb_we=0 until a new request.
